// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch front end: fetch FSM states, the IF/ID
// register layout and the default bubble instruction.
package mips_pkg;

  localparam int unsigned IFID_ADDR_W = 32;
  localparam int unsigned IFID_DATA_W = 32;
  localparam logic [IFID_DATA_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic                   valid;
    logic [IFID_DATA_W-1:0] instr;
    logic [IFID_ADDR_W-1:0] pc_plus_4;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry parking register for a fetched word that arrived while decode was
// stalled. Load captures an entry; unload or clear empties it.
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     unload,
  input  logic                     clear,
  input  logic [$bits(ifid_t)-1:0] din,
  output logic [$bits(ifid_t)-1:0] dout,
  output logic                     empty
);

  logic  full_q, full_d;
  ifid_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end
    if (unload || clear) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // Payload only matters while full, so it carries no reset.
  always_ff @(posedge clk) data_q <= data_d;

  assign dout  = data_q;
  assign empty = !full_q;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction-fetch stage: one outstanding imem request, IF/ID register, hold
// buffer for decode stalls, flush handling. FETCH_PERF_CNT_EN adds counters.
module if_id_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cur_pc,
  input  logic [ADDR_W-1:0] pc_plus_4,
  output logic              pc_stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              id_stall,
  input  logic              flush,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus_4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc4_q, req_pc4_d;
  ifid_t             ifid_q, ifid_d, rsp_word, hold_dout;
  logic              req_fire, ifid_load;
  logic              hold_load, hold_unload, hold_clear, hold_empty;

  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_addr      = cur_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_word       = '{valid: 1'b1, instr: imem_rsp_data, pc_plus_4: req_pc4_q};

  always_comb begin
    state_d     = state_q;
    req_pc4_d   = req_pc4_q;
    ifid_d      = ifid_q;
    ifid_load   = 1'b0;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    hold_clear  = 1'b0;
    if (flush) begin
      // Redirect beats everything: kill IF/ID and the parked word, and
      // remember to swallow any response still owed by memory.
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      hold_clear   = 1'b1;
      case (state_q)
        S_REQ:   if (req_fire) state_d = S_DROP;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        default: if (imem_rsp_valid) state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc4_d = pc_plus_4;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid && !id_stall) begin
            ifid_d    = rsp_word;
            ifid_load = 1'b1;
            state_d   = S_REQ;
          end else if (imem_rsp_valid) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!id_stall && !hold_empty) begin
            ifid_d      = hold_dout;
            ifid_load   = 1'b1;
            hold_unload = 1'b1;
            state_d     = S_REQ;
          end
        end
        default: if (imem_rsp_valid) state_d = S_REQ;
      endcase
    end
  end

  // The PC advances exactly once per word delivered to decode, or on redirect.
  assign pc_stall = !(ifid_load || flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      ifid_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc_plus_4: '0};
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
    end
  end

  always_ff @(posedge clk) req_pc4_q <= req_pc4_d;

  fetch_hold_buf u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hold_load),
    .unload (hold_unload),
    .clear  (hold_clear),
    .din    (rsp_word),
    .dout   (hold_dout),
    .empty  (hold_empty)
  );

  assign ifid_valid     = ifid_q.valid;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc_plus_4 = ifid_q.pc_plus_4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(ifid_load);
    stall_cnt_d = stall_cnt_q + 32'(pc_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Counter-free build: no perf ports or state.
`endif

`ifndef SYNTHESIS
  // A response is legal in S_REQ only as a leftover from before reset,
  // i.e. before the first request has been accepted.
  logic fresh_q, fresh_d;

  always_comb fresh_d = fresh_q && !req_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fresh_q <= 1'b1;
    else        fresh_q <= fresh_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_REQ && imem_rsp_valid)
      assert (fresh_q) else $error("if_id_fetch: imem response with no request outstanding");
  end
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Bench for if_id_fetch: PC/memory environment, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_if_id_fetch;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cur_pc, pc_plus_4, imem_addr, imem_rsp_data;
  logic [31:0] ifid_instr, ifid_pc_plus_4;
  logic        pc_stall, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        id_stall, flush, ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_id_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cur_pc         (cur_pc),
    .pc_plus_4      (pc_plus_4),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_stall       (id_stall),
    .flush          (flush),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus_4 (ifid_pc_plus_4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Environment controls
  int          ready_mode = 1;   // 0 random, 1 always, 2 never
  int          lat_fixed = 0;    // <0 random 0..3
  bit          force_stray = 0;
  logic [31:0] flush_target = 0;
  logic [31:0] wq[$];

  // PC register and instruction memory
  initial begin : env
    bit          acc_s, gave_s, flush_s, stall_s, busy;
    int          wait_left;
    logic [31:0] tgt_s, pc, cur_word;
    busy = 0; wait_left = 0; pc = 0; cur_word = 0;
    forever begin
      @(negedge clk);
      acc_s   = rst_n && imem_req_valid && imem_req_ready;
      gave_s  = imem_rsp_valid;
      flush_s = flush;
      stall_s = pc_stall;
      tgt_s   = flush_target;
      @(posedge clk); #1;
      if (!rst_n) begin
        busy = 0; pc = 0; imem_rsp_valid = 1'b0;
      end else begin
        if (flush_s) pc = tgt_s;
        else if (!stall_s) pc = pc + 4;
        if (gave_s) busy = 0;
        if (acc_s) begin
          busy      = 1;
          wait_left = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
          cur_word  = (wq.size() != 0) ? wq.pop_front() : $urandom;
        end else if (busy && wait_left > 0) begin
          wait_left--;
        end
        imem_rsp_valid = (busy && wait_left == 0) || force_stray;
        force_stray = 0;
      end
      imem_rsp_data  = (busy && wait_left == 0) ? cur_word : $urandom;
      imem_req_ready = (ready_mode == 1) ? 1'b1 :
                       (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
      cur_pc    = pc;
      pc_plus_4 = pc + 4;
    end
  end

  // Transaction-level reference: outstanding request (live or killed),
  // parked word, and IF/ID contents.
  initial begin : compare
    bit          m_out, m_killed, m_hold, m_iv;
    logic [31:0] m_ii, m_ip, m_opc4, m_hi, m_hp;
    bit          exp_req, rsp, dlv_rsp, dlv_hold, acc;
    m_out = 0; m_killed = 0; m_hold = 0; m_iv = 0;
    m_ii = NOP; m_ip = 0; m_opc4 = 0; m_hi = 0; m_hp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ifid_valid", ifid_valid, 0);
        chk("rst_ifid_instr", ifid_instr, NOP);
        chk("rst_ifid_pc4", ifid_pc_plus_4, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        m_out = 0; m_killed = 0; m_hold = 0; m_iv = 0; m_ii = NOP; m_ip = 0;
      end else begin
        exp_req  = !m_out && !m_hold;
        rsp      = m_out && imem_rsp_valid;
        dlv_rsp  = !flush && rsp && !m_killed && !id_stall;
        dlv_hold = !flush && m_hold && !id_stall;
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, cur_pc);
        chk("pc_stall", pc_stall, !(dlv_rsp || dlv_hold || flush));
        chk("ifid_valid", ifid_valid, m_iv);
        chk("ifid_instr", ifid_instr, m_ii);
        if (m_iv) chk("ifid_pc4", ifid_pc_plus_4, m_ip);
        acc = exp_req && imem_req_ready;
        if (flush) begin
          m_iv = 0; m_ii = NOP; m_hold = 0;
          if (rsp) m_out = 0;
          else if (m_out) m_killed = 1;
          if (acc) begin m_out = 1; m_killed = 1; end
        end else begin
          if (dlv_hold) begin m_iv = 1; m_ii = m_hi; m_ip = m_hp; m_hold = 0; end
          if (rsp) begin
            m_out = 0;
            if (!m_killed && id_stall) begin m_hold = 1; m_hi = imem_rsp_data; m_hp = m_opc4; end
            else if (!m_killed) begin m_iv = 1; m_ii = imem_rsp_data; m_ip = m_opc4; end
          end
          if (acc) begin m_out = 1; m_killed = 0; m_opc4 = pc_plus_4; end
        end
      end
    end
  end

  task automatic at_drive();
    @(posedge clk); #2;
  endtask

  task automatic at_obs();
    @(negedge clk);
  endtask

  task automatic expect_ifid(input string name, input logic [31:0] instr, input logic [31:0] pc4);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      at_obs();
      if (ifid_valid && ifid_instr == instr) found = 1;
    end
    chk({name, "_arrived"}, found, 1);
    chk({name, "_pc4"}, ifid_pc_plus_4, pc4);
  endtask

  task automatic wait_accept(input string name);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      at_obs();
      if (imem_req_valid && imem_req_ready) found = 1;
    end
    chk({name, "_accepted"}, found, 1);
  endtask

  initial begin : main
    int n, n2;
    flush = 0; id_stall = 0; cur_pc = 0; pc_plus_4 = 4;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // 1: zero-wait memory, two words back to back
    ready_mode = 1; lat_fixed = 0;
    wq.push_back(32'h20080005);
    wq.push_back(32'h20090007);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    expect_ifid("t1_w0", 32'h20080005, 32'd4);
    expect_ifid("t1_w1", 32'h20090007, 32'd8);
    n = 0;
    for (int i = 0; i < 8; i++) begin at_obs(); if (!pc_stall) n++; end
    chk("t1_pc_stall_lows_in_8", n, 4);

    // 2: response three cycles late
    at_drive(); lat_fixed = 3; wq.push_back(32'h01234567);
    wait_accept("t2");
    n = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      at_obs();
      if (!pc_stall) break;
      n++;
      if (!imem_req_valid) n2++;
    end
    chk("t2_stall_cycles", n, 3);
    chk("t2_req_low_cycles", n2, 3);
    at_obs();
    chk("t2_ifid_instr", ifid_instr, 32'h01234567);

    // 3: decode stalled when the word arrives
    at_drive(); lat_fixed = 1; wq.push_back(32'hAC010000);
    wait_accept("t3");
    at_drive(); id_stall = 1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      at_obs();
      if (!pc_stall) n++;
      chk("t3_ifid_frozen", ifid_instr == 32'hAC010000, 0);
    end
    at_drive(); id_stall = 0;
    at_obs();
    if (!pc_stall) n++;
    chk("t3_release_pc_stall", pc_stall, 0);
    at_obs();
    if (!pc_stall) n++;
    chk("t3_ifid_instr", ifid_instr, 32'hAC010000);
    chk("t3_ifid_valid", ifid_valid, 1);
    chk("t3_single_pulse", n, 1);

    // 4: flush while waiting, late response discarded
    at_drive(); lat_fixed = 2; wq.push_back(32'hDEADBEEF);
    wait_accept("t4");
    at_drive(); flush = 1; flush_target = 32'h400;
    at_obs();
    chk("t4_flush_pc_stall", pc_stall, 0);
    at_drive(); flush = 0;
    at_obs();
    chk("t4_ifid_valid", ifid_valid, 0);
    chk("t4_ifid_nop", ifid_instr, NOP);
    chk("t4_drop_req_low", imem_req_valid, 0);
    at_obs();
    chk("t4_drop_req_low2", imem_req_valid, 0);
    at_obs();
    chk("t4_redirect_req", imem_req_valid, 1);
    chk("t4_redirect_addr", imem_addr, 32'h400);
    at_obs();
    chk("t4_no_deadbeef", ifid_valid, 0);

    // 5: flush coincident with the response
    at_drive(); lat_fixed = 0;
    wait_accept("t5");
    at_drive(); flush = 1; flush_target = 32'h800;
    at_obs();
    chk("t5_flush_pc_stall", pc_stall, 0);
    at_drive(); flush = 0;
    at_obs();
    chk("t5_req_no_drop", imem_req_valid, 1);
    chk("t5_addr", imem_addr, 32'h800);
    chk("t5_ifid_valid", ifid_valid, 0);

    // 6: async reset while a word is parked, stray response afterwards
    at_drive();
    wait_accept("t6");
    at_drive(); id_stall = 1;
    at_obs();
    chk("t6_hold_pc_stall", pc_stall, 1);
    @(posedge clk); #3;
    rst_n = 1'b0; ready_mode = 2; force_stray = 1; id_stall = 0;
    #1;
    chk("t6_async_ifid_valid", ifid_valid, 0);
    chk("t6_async_ifid_instr", ifid_instr, NOP);
    chk("t6_async_ifid_pc4", ifid_pc_plus_4, 0);
    chk("t6_async_req_valid", imem_req_valid, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    at_obs();
    at_obs();
    chk("t6_stray_ifid_valid", ifid_valid, 0);
    chk("t6_stray_req_valid", imem_req_valid, 1);
    at_obs();
    chk("t6_after_stray_valid", ifid_valid, 0);

    // Randomized traffic against the reference model
    at_drive(); ready_mode = 0; lat_fixed = -1;
    for (int c = 0; c < 3000; c++) begin
      flush        = ($urandom_range(0, 99) < 6);
      flush_target = 32'($urandom_range(0, 4095)) << 2;
      id_stall     = ($urandom_range(0, 99) < 30);
      at_drive();
    end
    flush = 0; id_stall = 0;
    repeat (6) at_drive();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
